// File: rtl/stencil_1d.sv
// Two-tap 1-D stencil: B[i] = w0*A[i-1] + w1*A[i] for i = 1..SIZE-1, streamed one element per cycle.
// Latency: read i issued in cycle i+1, write i in cycle i+3; a run occupies cycles 1..SIZE+2 after the start pulse.
// Backpressure: none; memories are always ready, and start pulses while busy are ignored.
//
// Ports:
//   clk, rst (sync, active-low)    t: start pulse    w0/w1: weights, latched at start
//   Ai_p0_*: A read port (data returns the cycle after rd_en)
//   Bw_p0_*: B write port (registered strobe, address and data)
module stencil_1d #(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t,
  input  logic [WIDTH-1:0]  w0,
  input  logic [WIDTH-1:0]  w1,
  output logic              Ai_p0_addr_en,
  output logic [ADDR_W-1:0] Ai_p0_addr_data,
  output logic              Ai_p0_rd_en,
  input  logic [WIDTH-1:0]  Ai_p0_rd_data,
  output logic              Bw_p0_addr_en,
  output logic [ADDR_W-1:0] Bw_p0_addr_data,
  output logic              Bw_p0_wr_en,
  output logic [WIDTH-1:0]  Bw_p0_wr_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state;
  logic [WIDTH-1:0]    w0_q, w1_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  // d_vld/d_idx mark the cycle in which read data for address d_idx is on Ai_p0_rd_data.
  logic                d_vld;
  logic [ADDR_W-1:0]   d_idx;
  logic [WIDTH-1:0]    a_prev;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [WIDTH-1:0]    wr_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      w0_q      <= '0;
      w1_q      <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      d_vld     <= 1'b0;
      d_idx     <= '0;
      a_prev    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      d_vld <= rd_en_q;
      d_idx <= rd_addr_q;

      // a_prev always holds the element read just before the one now arriving,
      // so the arriving element and a_prev form the A[i]/A[i-1] pair.
      if (d_vld) a_prev <= Ai_p0_rd_data;

      // Element 0 has no left neighbour, so B[0] is never produced.
      wr_en_q <= d_vld && (d_idx != '0);
      if (d_vld && (d_idx != '0)) begin
        wr_addr_q <= d_idx;
        wr_data_q <= w0_q * a_prev + w1_q * Ai_p0_rd_data;
      end

      case (state)
        IDLE: begin
          if (t) begin
            w0_q      <= w0;
            w1_q      <= w1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (rd_addr_q == LAST) begin
            rd_en_q <= 1'b0;
            state   <= DRAIN;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          // Leave once the last read data has been consumed; its write is
          // already registered and goes out in this same cycle.
          if (!d_vld) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Ai_p0_addr_en   = rd_en_q;
  assign Ai_p0_rd_en     = rd_en_q;
  assign Ai_p0_addr_data = rd_addr_q;
  assign Bw_p0_addr_en   = wr_en_q;
  assign Bw_p0_wr_en     = wr_en_q;
  assign Bw_p0_addr_data = wr_addr_q;
  assign Bw_p0_wr_data   = wr_data_q;

endmodule

// File: tb/tb_stencil_1d.sv
module tb_stencil_1d;
  localparam int WIDTH  = 32;
  localparam int SIZE   = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              t = 1'b0;
  logic [WIDTH-1:0]  w0 = '0, w1 = '0;
  logic              ai_addr_en, ai_rd_en, bw_addr_en, bw_wr_en;
  logic [ADDR_W-1:0] ai_addr, bw_addr;
  logic [WIDTH-1:0]  ai_rd_data = '0;
  logic [WIDTH-1:0]  bw_wr_data;

  stencil_1d #(.WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .t(t), .w0(w0), .w1(w1),
    .Ai_p0_addr_en(ai_addr_en), .Ai_p0_addr_data(ai_addr), .Ai_p0_rd_en(ai_rd_en),
    .Ai_p0_rd_data(ai_rd_data),
    .Bw_p0_addr_en(bw_addr_en), .Bw_p0_addr_data(bw_addr), .Bw_p0_wr_en(bw_wr_en),
    .Bw_p0_wr_data(bw_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // A memory: synchronous read, data valid the cycle after rd_en.
  logic [WIDTH-1:0] a_mem [SIZE];
  always @(posedge clk) if (ai_rd_en === 1'b1) ai_rd_data <= a_mem[ai_addr];

  typedef struct packed { int cyc; int addr; logic [31:0] data; } ev_t;
  ev_t rd_q[$], wr_q[$], got_rd[$], got_wr[$], exp_rd[$], exp_wr[$];

  always @(negedge clk) begin
    checks++;
    if (ai_addr_en !== ai_rd_en || bw_addr_en !== bw_wr_en) begin
      errors++;
      $display("FAIL addr_en_tracks_en cyc=%0d a=%b/%b b=%b/%b required equal", cyc, ai_addr_en, ai_rd_en, bw_addr_en, bw_wr_en);
    end
    if (ai_rd_en === 1'b1) rd_q.push_back('{cyc, int'(ai_addr), 32'd0});
    if (bw_wr_en === 1'b1) wr_q.push_back('{cyc, int'(bw_addr), bw_wr_data});
  end

  // Reference model: a run started in cycle t0 reads A[i] in cycle t0+1+i and
  // writes B[i] = w0*A[i-1] + w1*A[i] (mod 2^32) in cycle t0+3+i; events after 'last' are cut off.
  task automatic build_exp(input int t0, input logic [31:0] w0v, input logic [31:0] w1v, input int last);
    exp_rd.delete();
    exp_wr.delete();
    for (int i = 0; i < SIZE; i++)
      if (t0 + 1 + i <= last) exp_rd.push_back('{t0 + 1 + i, i, 32'd0});
    for (int i = 1; i < SIZE; i++) begin
      logic [31:0] v;
      v = w0v * a_mem[i-1] + w1v * a_mem[i];
      if (t0 + 3 + i <= last) exp_wr.push_back('{t0 + 3 + i, i, v});
    end
  endtask

  task automatic grab(input int lo, input int hi);
    got_rd.delete();
    got_wr.delete();
    foreach (rd_q[k]) if (rd_q[k].cyc >= lo && rd_q[k].cyc <= hi) got_rd.push_back(rd_q[k]);
    foreach (wr_q[k]) if (wr_q[k].cyc >= lo && wr_q[k].cyc <= hi) got_wr.push_back(wr_q[k]);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives t high for the current cycle; returns that cycle number (cycle 0 of the run).
  task automatic pulse_t(output int t0);
    t0 = cyc;
    t = 1'b1;
    @(posedge clk); #1;
    t = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    t = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({ai_addr_en, ai_addr, ai_rd_en, bw_addr_en, bw_addr, bw_wr_en, bw_wr_data} !== 48'd0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got rd_en=%b addr=%0d wr_en=%b waddr=%0d wdata=%h required all 0",
                 cyc, ai_rd_en, ai_addr, bw_wr_en, bw_addr, bw_wr_data);
      end
    end
    t = 1'b0;
    rst = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || ai_rd_en !== 1'b0 || bw_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_access reads=%0d writes=%0d required 0/0", rd_q.size(), wr_q.size());
    end
  endtask

  task automatic test_basic;
    int t0;
    for (int k = 0; k < SIZE; k++) a_mem[k] = k;
    w0 = 2; w1 = 3;
    pulse_t(t0);
    wait_until(t0 + 72);
    build_exp(t0, 2, 3, t0 + 1000);
    grab(t0, t0 + 71);
    checks++;
    if (got_rd.size() != 64 || got_wr.size() != 63) begin
      errors++; $display("FAIL basic_counts reads=%0d writes=%0d required 64/63", got_rd.size(), got_wr.size());
    end
    foreach (exp_rd[k]) begin
      checks++;
      if (k >= got_rd.size() || got_rd[k] !== exp_rd[k]) begin
        errors++; $display("FAIL basic_rd[%0d] got=%h required=%h", k, got_rd[k], exp_rd[k]);
      end
    end
    foreach (exp_wr[k]) begin
      checks++;
      if (k >= got_wr.size() || got_wr[k] !== exp_wr[k]) begin
        errors++; $display("FAIL basic_wr[%0d] got=%h required=%h", k, got_wr[k], exp_wr[k]);
      end
    end
    checks++;
    if (got_wr.size() != 63 || got_wr[0].data !== 32'd3 || got_wr[62].data !== 32'd313) begin
      errors++; $display("FAIL basic_endpoints B1=%0d B63=%0d required 3/313", got_wr[0].data, got_wr[62].data);
    end
  endtask

  task automatic test_overflow;
    int t0;
    for (int k = 0; k < SIZE; k++) a_mem[k] = 32'hFFFF_FFFF;
    w0 = 2; w1 = 3;
    pulse_t(t0);
    wait_until(t0 + 72);
    build_exp(t0, 2, 3, t0 + 1000);
    grab(t0, t0 + 71);
    foreach (exp_wr[k]) begin
      checks++;
      if (k >= got_wr.size() || got_wr[k] !== exp_wr[k] || got_wr[k].data !== 32'hFFFF_FFFB) begin
        errors++; $display("FAIL overflow_wr[%0d] got=%h required=%h", k, got_wr[k], exp_wr[k]);
      end
    end
    checks++;
    if (got_rd.size() != 64 || got_wr.size() != 63) begin
      errors++; $display("FAIL overflow_counts reads=%0d writes=%0d required 64/63", got_rd.size(), got_wr.size());
    end
  endtask

  task automatic test_random_restart;
    int t0;
    logic [31:0] rw0, rw1;
    for (int k = 0; k < SIZE; k++) a_mem[k] = $urandom;
    rw0 = $urandom; rw1 = $urandom;
    w0 = rw0; w1 = rw1;
    pulse_t(t0);
    wait_until(t0 + 20);
    t = 1'b1;
    @(posedge clk); #1;
    t = 1'b0;
    wait_until(t0 + 80);
    build_exp(t0, rw0, rw1, t0 + 1000);
    grab(t0, t0 + 79);
    checks++;
    if (got_rd.size() != 64 || got_wr.size() != 63) begin
      errors++; $display("FAIL restart_counts reads=%0d writes=%0d required 64/63", got_rd.size(), got_wr.size());
    end
    foreach (exp_rd[k]) begin
      checks++;
      if (k >= got_rd.size() || got_rd[k] !== exp_rd[k]) begin
        errors++; $display("FAIL restart_rd[%0d] got=%h required=%h", k, got_rd[k], exp_rd[k]);
      end
    end
    foreach (exp_wr[k]) begin
      checks++;
      if (k >= got_wr.size() || got_wr[k] !== exp_wr[k]) begin
        errors++; $display("FAIL random_wr[%0d] got=%h required=%h", k, got_wr[k], exp_wr[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int t0, t1;
    for (int k = 0; k < SIZE; k++) a_mem[k] = $urandom_range(0, 1000);
    w0 = 2; w1 = 3;
    pulse_t(t0);
    wait_until(t0 + 10);
    w0 = 7;
    wait_until(t0 + 67);
    pulse_t(t1);
    wait_until(t1 + 72);
    build_exp(t0, 2, 3, t0 + 1000);
    grab(t0, t0 + 66);
    checks++;
    if (got_rd.size() != 64 || got_wr.size() != 63) begin
      errors++; $display("FAIL latch_counts reads=%0d writes=%0d required 64/63", got_rd.size(), got_wr.size());
    end
    foreach (exp_wr[k]) begin
      checks++;
      if (k >= got_wr.size() || got_wr[k] !== exp_wr[k]) begin
        errors++; $display("FAIL latch_wr[%0d] got=%h required=%h", k, got_wr[k], exp_wr[k]);
      end
    end
    build_exp(t1, 7, 3, t1 + 1000);
    grab(t1, t1 + 71);
    checks++;
    if (got_rd.size() != 64 || got_wr.size() != 63) begin
      errors++; $display("FAIL b2b_counts reads=%0d writes=%0d required 64/63", got_rd.size(), got_wr.size());
    end
    foreach (exp_rd[k]) begin
      checks++;
      if (k >= got_rd.size() || got_rd[k] !== exp_rd[k]) begin
        errors++; $display("FAIL b2b_rd[%0d] got=%h required=%h", k, got_rd[k], exp_rd[k]);
      end
    end
    foreach (exp_wr[k]) begin
      checks++;
      if (k >= got_wr.size() || got_wr[k] !== exp_wr[k]) begin
        errors++; $display("FAIL b2b_wr[%0d] got=%h required=%h", k, got_wr[k], exp_wr[k]);
      end
    end
  endtask

  task automatic test_mid_reset;
    int t0, t1;
    for (int k = 0; k < SIZE; k++) a_mem[k] = $urandom;
    w0 = 5; w1 = 32'hFFFF_FFFF;
    pulse_t(t0);
    wait_until(t0 + 30);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    wait_until(t0 + 75);
    build_exp(t0, 5, 32'hFFFF_FFFF, t0 + 30);
    grab(t0, t0 + 74);
    checks++;
    if (got_rd.size() != 30 || got_wr.size() != 27) begin
      errors++; $display("FAIL midreset_counts reads=%0d writes=%0d required 30/27", got_rd.size(), got_wr.size());
    end
    foreach (exp_rd[k]) begin
      checks++;
      if (k >= got_rd.size() || got_rd[k] !== exp_rd[k]) begin
        errors++; $display("FAIL midreset_rd[%0d] got=%h required=%h", k, got_rd[k], exp_rd[k]);
      end
    end
    foreach (exp_wr[k]) begin
      checks++;
      if (k >= got_wr.size() || got_wr[k] !== exp_wr[k]) begin
        errors++; $display("FAIL midreset_wr[%0d] got=%h required=%h", k, got_wr[k], exp_wr[k]);
      end
    end
    w0 = $urandom; w1 = $urandom;
    pulse_t(t1);
    wait_until(t1 + 72);
    build_exp(t1, w0, w1, t1 + 1000);
    grab(t1, t1 + 71);
    checks++;
    if (got_rd.size() != 64 || got_wr.size() != 63) begin
      errors++; $display("FAIL fresh_counts reads=%0d writes=%0d required 64/63", got_rd.size(), got_wr.size());
    end
    foreach (exp_wr[k]) begin
      checks++;
      if (k >= got_wr.size() || got_wr[k] !== exp_wr[k]) begin
        errors++; $display("FAIL fresh_wr[%0d] got=%h required=%h", k, got_wr[k], exp_wr[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required finish before timeout", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_overflow();
    test_random_restart();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
